pwm_capture: RTL and testbench

Measures an incoming PWM waveform, such as the LED drive produced from a fade generator's `pwm_value`, and recovers the period and the high time in clock cycles. It is the decode end of the PWM link. It sits between an asynchronous `pwm_in` pin and any logic that checks or displays the recovered duty. It also flags lines stuck at 0 % or 100 %.

---
 rtl/pwm_capture.sv | 60 ++++++
 tb/tb_pwm_capture.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: recovers period and high time of an asynchronous PWM line and flags lines stuck high or low
module pwm_capture #(
    parameter int PWM_INTERVAL = 1200,
    parameter int TIMEOUT = 2400,
    parameter int CNT_W = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             valid,
    output logic             stuck_high,
    output logic             stuck_low
);
    typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    state_t state;
    logic s1, s2, s3;
    logic [CNT_W-1:0] period_cnt, high_cnt;
    logic rise, timeout;
    assign rise = s2 & ~s3;
    assign timeout = period_cnt == CNT_MAX;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            {s1, s2, s3} <= '0;
            period_cnt <= '0;
            high_cnt <= '0;
            high_count <= '0;
            period_count <= '0;
            valid <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low <= 1'b0;
        end else begin
            {s1, s2, s3} <= {pwm_in, s1, s2};
            valid <= 1'b0;
            period_cnt <= rise ? CNT_W'(1) : timeout ? period_cnt : period_cnt + CNT_W'(1);
            high_cnt <= rise ? CNT_W'(1) : (s2 && high_cnt != CNT_MAX) ? high_cnt + CNT_W'(1) : high_cnt;
            // a rise outside MEASURE only starts a period; the partial one before it is not reported
            if (rise) begin
                state <= MEASURE;
                if (state == MEASURE) begin
                    high_count <= high_cnt;
                    period_count <= period_cnt;
                    valid <= 1'b1;
                    stuck_high <= 1'b0;
                    stuck_low <= 1'b0;
                end
            end else if (timeout && state != STUCK) begin
                state <= STUCK;
                period_count <= '0;
                high_count <= s2 ? CNT_W'(PWM_INTERVAL) : '0;
                stuck_high <= s2;
                stuck_low <= ~s2;
                valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of period/high recovery, latency, stuck detection, boundaries and reset
module tb_pwm_capture;
    logic clk = 1'b0;
    logic rst, pwm_in;
    logic [11:0] high_count, period_count;
    logic valid, stuck_high, stuck_low;
    int checks = 0;
    int fails = 0;
    int nvalid = 0;
    int v_idx = 0;
    logic [31:0] v_hc = 0, v_pc = 0, v_sh = 0, v_sl = 0;

    pwm_capture dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .high_count(high_count), .period_count(period_count),
        .valid(valid), .stuck_high(stuck_high), .stuck_low(stuck_low)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // hold pwm_in at lvl for n clock edges, recording the last valid pulse seen
    task automatic hold(input logic lvl, input int n);
        pwm_in = lvl;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                nvalid++;
                v_idx = i;
                v_hc = 32'(high_count);
                v_pc = 32'(period_count);
                v_sh = 32'(stuck_high);
                v_sl = 32'(stuck_low);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_high_count", 32'(high_count), 0);
        chk("reset_period_count", 32'(period_count), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_stuck_high", 32'(stuck_high), 0);
        chk("reset_stuck_low", 32'(stuck_low), 0);
        rst = 1'b0;

        nvalid = 0;
        for (int k = 0; k < 4; k++) begin
            hold(1'b1, 300);
            hold(1'b0, 900);
        end
        chk("steady_nvalid", nvalid, 3);
        chk("steady_high", v_hc, 300);
        chk("steady_period", v_pc, 1200);
        chk("steady_sh", v_sh, 0);
        chk("steady_sl", v_sl, 0);

        pwm_in = 1'b1;
        @(posedge clk); #1;
        chk("lat_edge0", 32'(valid), 0);
        @(posedge clk); #1;
        chk("lat_edge1", 32'(valid), 0);
        @(posedge clk); #1;
        chk("lat_edge2", 32'(valid), 1);
        chk("lat_high", 32'(high_count), 300);
        chk("lat_period", 32'(period_count), 1200);
        hold(1'b1, 297);
        chk("hold_high", 32'(high_count), 300);
        chk("hold_valid", 32'(valid), 0);
        hold(1'b0, 900);

        nvalid = 0;
        hold(1'b1, 3000);
        chk("sh_nvalid", nvalid, 2);
        chk("sh_when", v_idx, 2403);
        chk("sh_high", v_hc, 1200);
        chk("sh_period", v_pc, 0);
        chk("sh_flag", v_sh, 1);
        chk("sh_sl", v_sl, 0);
        nvalid = 0;
        hold(1'b0, 900);
        hold(1'b1, 300);
        chk("sh_partial_nvalid", nvalid, 0);
        chk("sh_flag_holds", 32'(stuck_high), 1);
        hold(1'b0, 900);
        hold(1'b1, 3);
        chk("sh_clear_nvalid", nvalid, 1);
        chk("sh_clear_high", v_hc, 300);
        chk("sh_clear_period", v_pc, 1200);
        chk("sh_clear_flag", v_sh, 0);

        rst = 1'b1;
        hold(1'b0, 3);
        rst = 1'b0;
        nvalid = 0;
        hold(1'b0, 2500);
        chk("sl_nvalid", nvalid, 1);
        chk("sl_when", v_idx, 2401);
        chk("sl_high", v_hc, 0);
        chk("sl_period", v_pc, 0);
        chk("sl_flag", v_sl, 1);
        chk("sl_sh", v_sh, 0);

        nvalid = 0;
        hold(1'b1, 1200);
        chk("b_restart_nvalid", nvalid, 0);
        hold(1'b0, 1200);
        hold(1'b1, 1200);
        chk("b2400_nvalid", nvalid, 1);
        chk("b2400_period", v_pc, 2400);
        chk("b2400_high", v_hc, 1200);
        chk("b2400_sl", v_sl, 0);
        chk("b2400_sh", v_sh, 0);
        nvalid = 0;
        hold(1'b0, 1201);
        hold(1'b1, 5);
        chk("b2401_nvalid", nvalid, 1);
        chk("b2401_period", v_pc, 0);
        chk("b2401_high", v_hc, 0);
        chk("b2401_sl", v_sl, 1);
        chk("b2401_sl_holds", 32'(stuck_low), 1);
        hold(1'b1, 295);
        hold(1'b0, 900);
        nvalid = 0;
        hold(1'b1, 100);
        chk("recover_nvalid", nvalid, 1);
        chk("recover_high", v_hc, 300);
        chk("recover_period", v_pc, 1200);
        chk("recover_sl", 32'(stuck_low), 0);

        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_high", 32'(high_count), 0);
        chk("mid_rst_period", 32'(period_count), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_sh", 32'(stuck_high), 0);
        chk("mid_rst_sl", 32'(stuck_low), 0);
        rst = 1'b0;
        nvalid = 0;
        hold(1'b1, 50);
        hold(1'b0, 100);
        chk("mid_rst_first_rise", nvalid, 0);
        hold(1'b1, 5);
        chk("mid_rst_nvalid", nvalid, 1);
        chk("mid_rst_meas_high", v_hc, 50);
        chk("mid_rst_meas_period", v_pc, 150);

        nvalid = 0;
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 3);
        chk("min_nvalid", nvalid, 2);
        chk("min_high", v_hc, 1);
        chk("min_period", v_pc, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
